// File: rtl/sram16_host_ctrl.sv
// Byte-serial host controller for a single-port 32-bit SRAM macro.
// Command frames arrive on an 8-bit valid/ready stream; read data returns LSB-first on another.
module sram16_host_ctrl #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  output logic              sram_cs,
  output logic [3:0]        sram_wen,
  input  logic [DATA_W-1:0] sram_rdata
);

  typedef enum logic [2:0] {
    OPC, ADDR_HI, ADDR_LO, WDATA, MEM_WR, MEM_RD, RD_WAIT, RESP
  } state_t;

  localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

  state_t              state, state_nxt;
  logic                run;
  logic                op_wr;
  logic [3:0]          op_be;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-9:0]   hi_q;
  logic [ADDR_W-1:0]   addr_new;
  logic [1:0]          cnt;
  logic [1:0]          wait_cnt;
  logic [23:0]         wbuf;
  logic [DATA_W-1:0]   rbuf;
  logic                in_acc;
  logic                out_acc;

  assign in_acc   = in_valid & in_ready;
  assign out_acc  = out_valid & out_ready;
  assign addr_new = {hi_q, in_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= OPC;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      OPC: begin
        if (in_acc) begin
          if (in_data[5]) state_nxt = in_data[7] ? WDATA : MEM_RD;
          else            state_nxt = ADDR_HI;
        end
      end
      ADDR_HI: if (in_acc) state_nxt = ADDR_LO;
      ADDR_LO: if (in_acc) state_nxt = op_wr ? WDATA : MEM_RD;
      WDATA:   if (in_acc && cnt == 2'd3) state_nxt = MEM_WR;
      MEM_WR:  state_nxt = OPC;
      MEM_RD:  state_nxt = RD_WAIT;
      RD_WAIT: if (wait_cnt == LAT_LAST) state_nxt = RESP;
      RESP:    if (out_acc && cnt == 2'd3) state_nxt = OPC;
      default: state_nxt = OPC;
    endcase
  end

  always_comb begin
    in_ready  = run && (state == OPC || state == ADDR_HI ||
                        state == ADDR_LO || state == WDATA);
    busy      = (state != OPC);
    sram_cs   = (state == MEM_RD) || (state == MEM_WR && op_be != 4'd0);
    sram_wen  = (state == MEM_WR) ? op_be : 4'd0;
    out_valid = (state == RESP);
    out_data  = out_valid ? rbuf[cnt*8 +: 8] : 8'd0;
  end

  // sram_addr is loaded on the edge entering MEM_*; addr_q advances once the access has happened.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run        <= 1'b0;
      op_wr      <= 1'b0;
      op_be      <= '0;
      addr_q     <= '0;
      hi_q       <= '0;
      cnt        <= '0;
      wait_cnt   <= '0;
      wbuf       <= '0;
      rbuf       <= '0;
      sram_addr  <= '0;
      sram_wdata <= '0;
    end else begin
      run <= 1'b1;
      unique case (state)
        OPC: begin
          if (in_acc) begin
            op_wr <= in_data[7];
            op_be <= in_data[3:0];
            cnt   <= '0;
            if (in_data[5] && !in_data[7]) sram_addr <= addr_q;
          end
        end
        ADDR_HI: if (in_acc) hi_q <= in_data[ADDR_W-9:0];
        ADDR_LO: begin
          if (in_acc) begin
            addr_q <= addr_new;
            if (!op_wr) sram_addr <= addr_new;
          end
        end
        WDATA: begin
          if (in_acc) begin
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              sram_wdata <= DATA_W'({in_data, wbuf});
              sram_addr  <= addr_q;
            end else begin
              wbuf[cnt*8 +: 8] <= in_data;
            end
          end
        end
        MEM_WR, MEM_RD: begin
          addr_q   <= addr_q + 1'b1;
          wait_cnt <= '0;
        end
        RD_WAIT: begin
          wait_cnt <= wait_cnt + 2'd1;
          if (wait_cnt == LAT_LAST) rbuf <= sram_rdata;
        end
        RESP: if (out_acc) cnt <= cnt + 2'd1;
        default: ;
      endcase
    end
  end

endmodule
